// File: rtl/gvram_seq.sv
// Graphics VRAM sequencer: shares one VRAM between R/G/B display fetches and
// CPU accesses using an 8-phase slot schedule driven by the free-running cnt.
module gvram_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BLANK,
    input  logic        VSTART,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [1:0]  cpu_plane,
    input  logic [7:0]  cpu_din,
    input  logic [7:0]  DB_IN,
    output logic [2:0]  cnt,
    output logic [12:0] VA,
    output logic [1:0]  VPLANE,
    output logic        nVCS,
    output logic        nVOE,
    output logic        nVWE,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout
);

    logic [2:0]  cnt_reg, cnt_next;
    logic        blank_q_reg, blank_next;
    logic [12:0] disp_addr_reg;
    logic        busy_reg, we_reg, ack_reg;
    logic [12:0] addr_reg;
    logic [1:0]  plane_reg;
    logic [7:0]  data_reg, dout_reg;
    logic        cpu_slot_next, grant, access_done, disp_fetch;

    // Grants are decided on the edge entering a slot's first (odd) phase, so
    // the whole two-phase access is driven from registered values.
    always_comb begin
        cnt_next      = cnt_reg + 3'd1;
        blank_next    = (cnt_reg == 3'd0) ? BLANK : blank_q_reg;
        cpu_slot_next = blank_next || (cnt_next == 3'd7);
        grant         = cnt_next[0] && cpu_slot_next && cpu_req && !busy_reg;
        access_done   = busy_reg && !cnt_reg[0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg       <= 3'd0;
            blank_q_reg   <= 1'b1;
            disp_addr_reg <= 13'd0;
            busy_reg      <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 13'd0;
            plane_reg     <= 2'd0;
            data_reg      <= 8'd0;
            ack_reg       <= 1'b0;
            dout_reg      <= 8'd0;
        end else begin
            cnt_reg     <= cnt_next;
            blank_q_reg <= blank_next;
            if (VSTART)
                disp_addr_reg <= 13'd0;
            else if (cnt_reg == 3'd6 && !blank_q_reg)
                disp_addr_reg <= disp_addr_reg + 13'd1;
            ack_reg <= access_done;
            if (grant) begin
                busy_reg  <= 1'b1;
                we_reg    <= cpu_we;
                addr_reg  <= cpu_addr;
                plane_reg <= cpu_plane;
                data_reg  <= cpu_din;
            end else if (access_done) begin
                busy_reg <= 1'b0;
            end
            if (access_done && !we_reg)
                dout_reg <= (plane_reg == 2'd3) ? 8'hFF : DB_IN;
        end
    end

    // Display and CPU accesses never overlap: CPU grants only land in CPU slots.
    always_comb begin
        disp_fetch = !blank_q_reg && (cnt_reg != 3'd0) && (cnt_reg != 3'd7);
        VA     = 13'd0;
        VPLANE = 2'd0;
        nVCS   = 1'b1;
        nVOE   = 1'b1;
        nVWE   = 1'b1;
        DB_OE  = 1'b0;
        DB_OUT = 8'd0;
        if (disp_fetch) begin
            VA     = disp_addr_reg;
            VPLANE = (cnt_reg <= 3'd2) ? 2'd0 : (cnt_reg <= 3'd4) ? 2'd1 : 2'd2;
            nVCS   = 1'b0;
            nVOE   = 1'b0;
        end else if (busy_reg && plane_reg != 2'd3) begin
            VA     = addr_reg;
            VPLANE = plane_reg;
            nVCS   = 1'b0;
            if (we_reg) begin
                DB_OE  = 1'b1;
                DB_OUT = data_reg;
                nVWE   = cnt_reg[0];
            end else begin
                nVOE = 1'b0;
            end
        end
    end

    assign cnt      = cnt_reg;
    assign cpu_ack  = ack_reg;
    assign cpu_dout = dout_reg;

endmodule

// File: tb/tb_gvram_seq.sv
// Bench for gvram_seq: phase-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_gvram_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BLANK = 1'b0;
    logic        VSTART = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = 13'd0;
    logic [1:0]  cpu_plane = 2'd0;
    logic [7:0]  cpu_din = 8'd0;
    logic [7:0]  DB_IN = 8'd0;
    logic [2:0]  cnt;
    logic [12:0] VA;
    logic [1:0]  VPLANE;
    logic        nVCS, nVOE, nVWE, DB_OE, cpu_ack;
    logic [7:0]  DB_OUT, cpu_dout;

    int checks = 0;
    int errors = 0;

    gvram_seq dut (
        .CLK(CLK), .RST(RST), .BLANK(BLANK), .VSTART(VSTART),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_plane(cpu_plane), .cpu_din(cpu_din), .DB_IN(DB_IN),
        .cnt(cnt), .VA(VA), .VPLANE(VPLANE), .nVCS(nVCS), .nVOE(nVOE),
        .nVWE(nVWE), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .cpu_ack(cpu_ack),
        .cpu_dout(cpu_dout)
    );

    always #31 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute cycle numbers, the group's blank flag and one
    // access record (start cycle = first slot phase, ack two cycles later).
    int          m_phase = 0;
    int          m_disp = 0;
    bit          m_blank = 1'b1;
    longint      m_cycle = 0;
    bit          acc_valid = 1'b0;
    longint      acc_start = 0;
    bit          acc_we = 1'b0;
    logic [12:0] acc_addr = 13'd0;
    logic [1:0]  acc_plane = 2'd0;
    logic [7:0]  acc_data = 8'd0;
    logic [7:0]  m_dout = 8'd0;
    int          m_nxt;
    logic [12:0] e_va;
    logic [1:0]  e_vp;
    logic        e_cs, e_oe, e_we, e_dboe, e_ack;
    logic [7:0]  e_dbo;

    initial forever begin
        @(posedge CLK);
        if (RST) begin
            m_phase = 0; m_blank = 1'b1; m_disp = 0; acc_valid = 1'b0; m_dout = 8'd0;
            m_cycle = m_cycle + 1;
        end else begin
            m_nxt = (m_phase + 1) % 8;
            if (acc_valid && m_cycle == acc_start + 1 && !acc_we)
                m_dout = (acc_plane == 2'd3) ? 8'hFF : DB_IN;
            if (VSTART) m_disp = 0;
            else if (m_phase == 6 && !m_blank) m_disp = (m_disp + 1) % 8192;
            if (m_phase == 0) m_blank = BLANK;
            if ((m_nxt % 2 == 1) && (m_blank || m_nxt == 7) && cpu_req &&
                (!acc_valid || m_cycle + 1 > acc_start + 2)) begin
                acc_valid = 1'b1; acc_start = m_cycle + 1;
                acc_we = cpu_we; acc_addr = cpu_addr; acc_plane = cpu_plane; acc_data = cpu_din;
            end
            m_cycle = m_cycle + 1;
            m_phase = m_nxt;
        end
        #1;
        e_va = 13'd0; e_vp = 2'd0; e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1;
        e_dboe = 1'b0; e_dbo = 8'd0;
        if (!m_blank && m_phase >= 1 && m_phase <= 6) begin
            e_va = 13'(m_disp); e_vp = 2'((m_phase - 1) / 2); e_cs = 1'b0; e_oe = 1'b0;
        end else if (acc_valid && (m_cycle == acc_start || m_cycle == acc_start + 1)
                     && acc_plane != 2'd3) begin
            e_va = acc_addr; e_vp = acc_plane; e_cs = 1'b0;
            if (acc_we) begin
                e_dboe = 1'b1; e_dbo = acc_data; e_we = (m_cycle == acc_start);
            end else begin
                e_oe = 1'b0;
            end
        end
        e_ack = acc_valid && (m_cycle == acc_start + 2);
        check("outputs", {cnt, VA, VPLANE, nVCS, nVOE, nVWE, DB_OE, DB_OUT, cpu_ack, cpu_dout},
              {3'(m_phase), e_va, e_vp, e_cs, e_oe, e_we, e_dboe, e_dbo, e_ack, m_dout});
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (cnt != 3'(p) && n < 16) begin
            tick();
            n++;
        end
        check("wait_phase", cnt, p);
    endtask

    task automatic rand_cycle(input bit wild);
        tick();
        DB_IN = 8'($urandom);
        if (cpu_req && cpu_ack) begin
            cpu_req = 1'b0;
        end else if (!cpu_req && $urandom_range(3) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 13'($urandom);
            cpu_plane = 2'($urandom); cpu_din = 8'($urandom);
        end else if (cpu_req && $urandom_range(63) == 0) begin
            cpu_req = 1'b0;
        end
        if (wild) begin
            if ($urandom_range(15) == 0) BLANK = ~BLANK;
            VSTART = ($urandom_range(40) == 0);
        end
    endtask

    initial begin
        int p;
        int grp;
        int acks;

        repeat (3) @(posedge CLK);
        #2;
        check("rst_cnt", cnt, 0);
        check("rst_VA", VA, 0);
        check("rst_strobes", {nVCS, nVOE, nVWE}, 3'b111);
        check("rst_DB", {DB_OE, DB_OUT}, 9'd0);
        check("rst_ack_dout", {cpu_ack, cpu_dout}, 9'd0);
        RST = 1'b0;

        // Display-only groups
        grp = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p = int'(cnt);
            check("A_nVOE", nVOE, (p >= 1 && p <= 6) ? 1'b0 : 1'b1);
            if (p == 1 || p == 3 || p == 5) check("A_VPLANE", VPLANE, (p - 1) / 2);
            if (p == 1) begin
                check("A_VA", VA, grp);
                grp++;
            end
        end

        // CPU write in the S3 slot while displaying
        wait_phase(2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_plane = 2'd1; cpu_din = 8'h5A;
        for (int i = 0; i < 7; i++) begin
            tick();
            p = int'(cnt);
            check("B_DB_OE", DB_OE, (p == 7 || p == 0));
            check("B_nVWE", nVWE, (p != 0));
            check("B_ack", cpu_ack, (p == 1));
            if (p == 7) begin
                check("B_VA", VA, 13'h0123);
                check("B_VPLANE", VPLANE, 2'd1);
                check("B_DB_OUT", DB_OUT, 8'h5A);
                check("B_nVCS", nVCS, 1'b0);
            end
        end
        cpu_req = 1'b0;
        BLANK = 1'b1;

        // CPU read during blanking
        wait_phase(0);
        wait_phase(2);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF; cpu_plane = 2'd0; DB_IN = 8'hC3;
        tick();
        check("C_cnt", cnt, 3);
        check("C_rd_strobes", {nVCS, nVOE, nVWE}, 3'b001);
        check("C_VA", VA, 13'h1FFF);
        check("C_ack_early", cpu_ack, 1'b0);
        tick();
        check("C_nVOE2", nVOE, 1'b0);
        tick();
        check("C_ack", cpu_ack, 1'b1);
        check("C_dout", cpu_dout, 8'hC3);
        cpu_req = 1'b0;

        // Continuous request during blanking: S0, S2, S0, ...
        wait_phase(0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100; cpu_plane = 2'd2;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p = int'(cnt);
            check("D_nVCS", nVCS, !(p == 1 || p == 2 || p == 5 || p == 6));
            check("D_ack", cpu_ack, (p == 3 || p == 7));
            acks += int'(cpu_ack);
        end
        check("D_acks", acks, 4);
        cpu_req = 1'b0;

        // VSTART clear beats the phase-6 increment
        BLANK = 1'b0;
        wait_phase(0);
        wait_phase(2);
        VSTART = 1'b1;
        tick();
        VSTART = 1'b0;
        repeat (5) begin
            wait_phase(6);
            tick();
        end
        wait_phase(1);
        check("E_VA5", VA, 13'd5);
        wait_phase(6);
        VSTART = 1'b1;
        tick();
        VSTART = 1'b0;
        wait_phase(1);
        check("E_VA_clr", VA, 13'd0);

        // Reset in the second phase of a CPU write
        wait_phase(2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0AAA; cpu_plane = 2'd0; cpu_din = 8'h3C;
        wait_phase(7);
        check("F_wr1", {DB_OE, nVWE}, 2'b11);
        wait_phase(0);
        check("F_wr2", {DB_OE, nVWE}, 2'b10);
        RST = 1'b1;
        #1;
        check("F_rst_strobes", {nVCS, nVOE, nVWE, DB_OE}, 4'b1110);
        check("F_rst_cnt", cnt, 0);
        check("F_rst_DB_OUT", DB_OUT, 8'd0);
        cpu_req = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        tick();
        check("F_cnt_restart", cnt, 1);
        check("F_no_ack1", cpu_ack, 1'b0);
        tick();
        check("F_no_ack2", cpu_ack, 1'b0);

        // Display address wrap 8191 -> 0, with random CPU traffic in S3
        wait_phase(2);
        VSTART = 1'b1;
        tick();
        VSTART = 1'b0;
        check("W_VA0", VA, 13'd0);
        repeat (8191 * 8) rand_cycle(1'b0);
        check("W_cnt", cnt, 3);
        check("W_VA_max", VA, 13'h1FFF);
        repeat (8) rand_cycle(1'b0);
        check("W_VA_wrap", VA, 13'd0);

        // Fully random traffic, blanking and frame starts
        repeat (3000) rand_cycle(1'b1);
        cpu_req = 1'b0;
        VSTART = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
